spi_cmd_decoder: RTL
====================

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter ADDR_W, default 24, memory byte-address width.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 frame_active  input  1  high while SPI slave select is asserted (synchronised to clk).
REQ-005 byte_valid  input  1  one-cycle strobe: byte_in holds a completed received SPI byte.
REQ-006 byte_in  input  8  received byte, valid only with byte_valid.
REQ-007 tx_byte  output  8  byte the SPI slave loads for the next outgoing byte.
REQ-008 mem_req  output  1  memory request, held high until acknowledged.
REQ-009 mem_we  output  1  write qualifier for mem_req (1 write, 0 read).
REQ-010 mem_addr  output  ADDR_W  request byte address.
REQ-011 mem_wdata  output  8  write data.
REQ-012 mem_rdata  input  8  read data, valid with mem_ack on a read.
REQ-013 mem_ack  input  1  one-cycle acknowledge completing the current request.
REQ-014 overrun  output  1  sticky: a byte arrived while a request was outstanding.

Function
REQ-015 States: IDLE, OPCODE, ADDR (ADDR_W/8 bytes, MSB first), WRITE, READ, STATUS, DROP.
REQ-016 IDLE->OPCODE when frame_active rises; any state->IDLE on the cycle frame_active is sampled low.
REQ-017 OPCODE decode on byte_valid: 0x02 write->ADDR, 0x03 read->ADDR, 0x05 status->STATUS, other->DROP.
REQ-018 ADDR shifts bytes into the address register; after the last address byte, go to WRITE or READ.
REQ-019 WRITE: each byte_valid raises mem_req with mem_we=1, mem_wdata=byte, mem_addr=current address; on mem_ack, drop mem_req and increment the address.
REQ-020 READ: on entry, issue a read immediately at the address; on mem_ack, latch mem_rdata into tx_byte, drop mem_req, increment the address.
REQ-021 READ: each later byte_valid issues the next read (prefetch), so the host clocks one dummy byte before the first data byte.
REQ-022 The address increments modulo 2^ADDR_W; 0xFFFFFF wraps to 0x000000.
REQ-023 mem_req is never high for more than one outstanding request; mem_addr, mem_we and mem_wdata are stable while mem_req is high.
REQ-024 byte_valid while mem_req is high: set overrun and discard the byte (no second request).
REQ-025 On frame end with mem_req high: keep the request until mem_ack, discard any read data, then go to IDLE.
REQ-026 A new frame does not leave IDLE while a request is outstanding.
REQ-027 STATUS: tx_byte = {6'b0, overrun, mem_req}; a byte_valid in STATUS clears overrun.
REQ-028 DROP ignores all bytes until frame end.
REQ-029 tx_byte = 0x00 in IDLE, OPCODE, ADDR, WRITE and DROP.
REQ-030 byte_valid coinciding with frame_active low is ignored.

Reset
REQ-031 rst forces state=IDLE, and sets mem_req, mem_we, mem_addr, mem_wdata, tx_byte, overrun and the checksum to 0.
REQ-032 rst mid-request drops mem_req immediately; a later mem_ack is ignored.

Configuration
REQ-033 With SPI_CHECKSUM_EN defined, an 8-bit sum (mod 256) accumulates every acknowledged write byte.
REQ-034 With SPI_CHECKSUM_EN defined, opcode 0x0B selects STATUS-style output where tx_byte = checksum, and a byte_valid in that state clears the sum.
REQ-035 Without SPI_CHECKSUM_EN, 0x0B is an unknown opcode (DROP) and no checksum logic exists.

Verification
REQ-036 Frame 02 00 10 00 AA BB, ack after 2 cycles -> writes 0xAA@0x001000, 0xBB@0x001001; overrun=0.
REQ-037 Frame 03 00 00 40 then 3 dummies, memory returns 11,22,33 -> tx_byte 11,22,33; addrs 0x40,0x41,0x42,0x43.
REQ-038 Write at 0xFFFFFF with 2 data bytes -> second write addr 0x000000.
REQ-039 Two byte_valid 1 cycle apart, ack held off 5 cycles -> one request, overrun=1; then status frame 05 00 -> tx_byte=0x02, next status 0x00.
REQ-040 frame_active low mid-write with req pending, ack 3 cycles later -> req held until ack, then IDLE; rst mid-req -> mem_req=0 next cycle.
REQ-041 SPI_CHECKSUM_EN: write 0x80,0x90 then 0B 00 -> tx_byte=0x10; without the macro, 0x0B -> DROP, tx_byte=0x00.

Source files
------------

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: opcode/address/data byte stream to a single-outstanding memory request port.
// Optional SPI_CHECKSUM_EN adds an 8-bit sum of acknowledged write bytes, read back with opcode 0x0B.
module spi_cmd_decoder #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_active,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [7:0]        tx_byte,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              overrun
);
    localparam int NAB = ADDR_W / 8;
    localparam int CW  = (NAB > 1) ? $clog2(NAB) : 1;
    localparam logic [CW-1:0] LAST_AB = CW'(NAB - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OPCODE, S_ADDR, S_WRITE, S_READ, S_STATUS, S_DROP
`ifdef SPI_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t          state, state_nxt;
    logic            is_wr;
    logic [CW-1:0]   addr_cnt;
    logic [7:0]      rd_data;
    logic            take;
    logic            ack;
`ifdef SPI_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    // A byte is only consumed when no request is outstanding; otherwise it is an overrun.
    assign take = byte_valid && frame_active && !mem_req;
    assign ack  = mem_ack && mem_req;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!frame_active) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (!mem_req) state_nxt = S_OPCODE;
                S_OPCODE: if (take) begin
                    case (byte_in)
                        8'h02, 8'h03: state_nxt = S_ADDR;
                        8'h05:        state_nxt = S_STATUS;
`ifdef SPI_CHECKSUM_EN
                        8'h0B:        state_nxt = S_CSUM;
`endif
                        default:      state_nxt = S_DROP;
                    endcase
                end
                S_ADDR:   if (take && addr_cnt == LAST_AB) state_nxt = is_wr ? S_WRITE : S_READ;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            S_READ:   tx_byte = rd_data;
            S_STATUS: tx_byte = {6'b0, overrun, mem_req};
`ifdef SPI_CHECKSUM_EN
            S_CSUM:   tx_byte = csum;
`endif
            default:  tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            overrun   <= 1'b0;
            is_wr     <= 1'b0;
            addr_cnt  <= '0;
            rd_data   <= 8'h00;
`ifdef SPI_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            if (state == S_OPCODE && take) begin
                is_wr    <= (byte_in == 8'h02);
                addr_cnt <= '0;
            end
            if (state == S_ADDR && take) begin
                mem_addr <= ADDR_W'({mem_addr, byte_in});
                addr_cnt <= addr_cnt + CW'(1);
                // Reads prefetch: the first read goes out as soon as the address is complete.
                if (addr_cnt == LAST_AB && !is_wr) begin
                    mem_req <= 1'b1;
                    mem_we  <= 1'b0;
                    rd_data <= 8'h00;
                end
            end
            if (state == S_WRITE && take) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_wdata <= byte_in;
            end
            if (state == S_READ && take) begin
                mem_req <= 1'b1;
                mem_we  <= 1'b0;
            end
            if (ack) begin
                mem_req  <= 1'b0;
                mem_addr <= mem_addr + ADDR_W'(1);
                // Read data that returns after the frame has ended is dropped.
                if (!mem_we && state == S_READ && frame_active) rd_data <= mem_rdata;
`ifdef SPI_CHECKSUM_EN
                if (mem_we) csum <= csum + mem_wdata;
`endif
            end
`ifdef SPI_CHECKSUM_EN
            if (state == S_CSUM && take) csum <= 8'h00;
`endif
            if (byte_valid && frame_active && mem_req) overrun <= 1'b1;
            else if (state == S_STATUS && take)        overrun <= 1'b0;
        end
    end
endmodule
